// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: funct3 encodings, FSM states,
// and the decode helpers used by the request path.
package lsu_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } lsu_state_t;

    // Unsigned loads have no store counterpart.
    function automatic logic f3_legal(input logic [2:0] f3, input logic we);
        case (f3)
            F3_B, F3_H, F3_W: f3_legal = 1'b1;
            F3_BU, F3_HU:     f3_legal = ~we;
            default:          f3_legal = 1'b0;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3)
            F3_H, F3_HU: f3_aligned = ~lo[0];
            F3_W:        f3_aligned = (lo == 2'b00);
            default:     f3_aligned = 1'b1;
        endcase
    endfunction

    // Loads always fetch the whole word; the lane is picked on return.
    function automatic logic [3:0] access_be(input logic [2:0] f3, input logic we,
                                             input logic [1:0] lo);
        access_be = 4'b1111;
        if (we) begin
            case (f3)
                F3_B:    access_be = 4'b0001 << lo;
                F3_H:    access_be = 4'b0011 << {lo[1], 1'b0};
                default: access_be = 4'b1111;
            endcase
        end
    endfunction

    function automatic logic [31:0] store_lanes(input logic [2:0] f3, input logic [31:0] wd);
        case (f3)
            F3_B:    store_lanes = {4{wd[7:0]}};
            F3_H:    store_lanes = {2{wd[15:0]}};
            default: store_lanes = wd;
        endcase
    endfunction

endpackage

// File: rtl/load_align.sv
// Selects the addressed byte/halfword lane of a read word and extends it
// according to the load type.
module load_align
    import lsu_pkg::*;
(
    input  logic [31:0] mem_rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        case (addr_lo_i)
            2'd0:    byte_sel = mem_rdata_i[7:0];
            2'd1:    byte_sel = mem_rdata_i[15:8];
            2'd2:    byte_sel = mem_rdata_i[23:16];
            default: byte_sel = mem_rdata_i[31:24];
        endcase
        half_sel = addr_lo_i[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];

        case (funct3_i)
            F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   data_o = {24'd0, byte_sel};
            F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
            F3_HU:   data_o = {16'd0, half_sel};
            default: data_o = mem_rdata_i;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// Memory-stage load/store unit: issues word-aligned bus requests with byte
// enables, stalls until completion and returns extended load data.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter int unsigned CNT_W          = 9
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_be,
    output logic [31:0] mem_wdata,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);

    lsu_state_t state_q, state_d;
    logic              mem_req_q, mem_req_d;
    logic              mem_we_q, mem_we_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [3:0]        mem_be_q, mem_be_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;
    logic [CNT_W-1:0]  wdog_q, wdog_d;
    logic [2:0]        ld_f3_q, ld_f3_d;
    logic [1:0]        ld_lo_q, ld_lo_d;

    logic [31:0]       load_data;
    logic              req_ok;
    logic              wdog_expired;

    load_align u_load_align (
        .mem_rdata_i (mem_rdata),
        .addr_lo_i   (ld_lo_q),
        .funct3_i    (ld_f3_q),
        .data_o      (load_data)
    );

    assign req_ok       = f3_legal(funct3, req_write) & f3_aligned(funct3, addr[1:0]);
    assign wdog_expired = (TIMEOUT_CYCLES != 0)
                        && ((wdog_q + CNT_W'(1)) == CNT_W'(TIMEOUT_CYCLES));

    always_comb begin
        state_d     = state_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        wdog_d      = wdog_q;
        ld_f3_d     = ld_f3_q;
        ld_lo_d     = ld_lo_q;

        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (req_ok) begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = req_write;
                        mem_addr_d  = {addr[31:2], 2'b00};
                        mem_be_d    = access_be(funct3, req_write, addr[1:0]);
                        mem_wdata_d = store_lanes(funct3, wdata);
                        ld_f3_d     = funct3;
                        ld_lo_d     = addr[1:0];
                        wdog_d      = '0;
                        state_d     = BUSY;
                    end else begin
                        err_d   = 1'b1;
                        state_d = RESP;
                    end
                end
            end
            BUSY: begin
                wdog_d = wdog_q + CNT_W'(1);
                // A response arriving on the last permitted cycle still wins.
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (!mem_we_q) begin
                        rdata_d = load_data;
                    end
                    state_d = RESP;
                end else if (wdog_expired) begin
                    mem_req_d = 1'b0;
                    err_d     = 1'b1;
                    state_d   = RESP;
                end
            end
            RESP: begin
                err_d   = 1'b0;
                state_d = IDLE;
            end
            default: begin
                mem_req_d = 1'b0;
                err_d     = 1'b0;
                state_d   = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_be_q    <= '0;
            mem_wdata_q <= '0;
            rdata_q     <= '0;
            err_q       <= 1'b0;
            wdog_q      <= '0;
            ld_f3_q     <= '0;
            ld_lo_q     <= '0;
        end else begin
            state_q     <= state_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            rdata_q     <= rdata_d;
            err_q       <= err_d;
            wdog_q      <= wdog_d;
            ld_f3_q     <= ld_f3_d;
            ld_lo_q     <= ld_lo_d;
        end
    end

    assign done      = (state_q == RESP);
    assign stall     = req_valid & ~done;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_be    = mem_be_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed and randomized accesses
// compared against an arithmetic reference model of the access rules.
module tb_load_store_unit;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        stall;
    logic        done;
    logic [31:0] rdata;
    logic        err;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_rdata = 32'd0;

    always #5 clk = ~clk;

    load_store_unit #(
        .TIMEOUT_CYCLES (TMO),
        .CNT_W          (3)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_write (req_write),
        .funct3    (funct3),
        .addr      (addr),
        .wdata     (wdata),
        .stall     (stall),
        .done      (done),
        .rdata     (rdata),
        .err       (err),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_be    (mem_be),
        .mem_wdata (mem_wdata),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] word);
        logic [31:0] b, h;
        b = (word >> (8 * (a % 4))) % 256;
        h = (word >> (8 * ((a % 4) / 2 * 2))) % 65536;
        case (f3)
            3'd0:    return (b >= 128) ? b - 32'd256 : b;
            3'd4:    return b;
            3'd1:    return (h >= 32768) ? h - 32'd65536 : h;
            3'd5:    return h;
            default: return word;
        endcase
    endfunction

    // One complete access; wait_n = cycles of mem_req before mem_ready.
    task automatic access(input logic w, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word, input int wait_n);
        bit          legal, aligned, got_ready, timed;
        int          size, n;
        logic [31:0] e_be, e_wd;

        legal   = (f3 <= 3'd2) || ((f3 == 3'd4 || f3 == 3'd5) && !w);
        size    = 1 << (f3 % 4);
        aligned = (a % size) == 0;
        e_be    = 32'd15;
        e_wd    = wd;
        if (w && f3 == 3'd0) begin
            e_be = 32'd1 << (a % 4);
            e_wd = (wd % 256) * 32'h01010101;
        end else if (w && f3 == 3'd1) begin
            e_be = 32'd3 << ((a % 4) / 2 * 2);
            e_wd = (wd % 65536) * 32'h00010001;
        end

        @(negedge clk);
        req_valid = 1'b1;
        req_write = w;
        funct3    = f3;
        addr      = a;
        wdata     = wd;
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        #1;
        chk("stall_accept", stall, 1);
        chk("req_low_accept", mem_req, 0);
        @(negedge clk);

        if (!(legal && aligned)) begin
            chk("bad_done", done, 1);
            chk("bad_err", err, 1);
            chk("bad_no_req", mem_req, 0);
            chk("bad_stall", stall, 0);
            chk("bad_rdata_hold", rdata, exp_rdata);
        end else begin
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, a - (a % 4));
            chk("mem_be", mem_be, e_be);
            chk("mem_we", mem_we, w);
            if (w) chk("mem_wdata", mem_wdata, e_wd);
            chk("busy_no_done", done, 0);
            n = 1;
            got_ready = 0;
            timed = 0;
            while (!got_ready && !timed) begin
                if (n - 1 == wait_n) begin
                    mem_ready = 1'b1;
                    mem_rdata = word;
                end else begin
                    mem_ready = 1'b0;
                    mem_rdata = $urandom;
                end
                @(negedge clk);
                if (n - 1 == wait_n) got_ready = 1;
                else if (n == TMO) timed = 1;
                else begin
                    chk("mem_req_hold", mem_req, 1);
                    chk("mem_addr_hold", mem_addr, a - (a % 4));
                    chk("stall_busy", stall, 1);
                end
                n++;
            end
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            chk("resp_done", done, 1);
            chk("resp_err", err, timed);
            chk("resp_req_low", mem_req, 0);
            chk("resp_stall", stall, 0);
            if (got_ready && !w) exp_rdata = model_load(f3, a, word);
            chk("rdata", rdata, exp_rdata);
        end

        @(negedge clk);
        req_valid = 1'b0;
        #1;
        chk("post_done", done, 0);
        chk("post_err", err, 0);
        chk("post_no_reissue", mem_req, 0);
        chk("post_stall", stall, 0);
    endtask

    initial begin
        logic        rw;
        logic [2:0]  rf3;
        logic [31:0] ra;

        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        funct3    = 3'd0;
        addr      = 32'd0;
        wdata     = 32'd0;
        mem_ready = 1'b0;
        mem_rdata = 32'd0;
        repeat (3) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_mem_req", mem_req, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_be", mem_be, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        rst_n = 1'b1;

        // mem_ready while idle is ignored
        @(negedge clk);
        mem_ready = 1'b1;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("idle_ready_ignored", done, 0);
        chk("idle_ready_no_req", mem_req, 0);

        access(1'b0, 3'd2, 32'h100, 32'd0, 32'hDEADBEEF, 0);
        access(1'b0, 3'd0, 32'h103, 32'd0, 32'h80123456, 0);
        access(1'b0, 3'd4, 32'h103, 32'd0, 32'h80123456, 1);
        access(1'b0, 3'd5, 32'h102, 32'd0, 32'hBEEF1234, 2);
        access(1'b1, 3'd0, 32'h21,  32'h12345678, 32'd0, 0);
        access(1'b1, 3'd1, 32'h22,  32'h12345678, 32'd0, 1);
        access(1'b1, 3'd2, 32'h40,  32'hCAFEF00D, 32'd0, 0);
        access(1'b0, 3'd2, 32'h102, 32'd0, 32'h11111111, 0);
        access(1'b1, 3'd6, 32'h100, 32'h5, 32'd0, 0);
        access(1'b1, 3'd4, 32'h100, 32'h5, 32'd0, 0);
        access(1'b0, 3'd1, 32'h301, 32'd0, 32'h0, 0);
        access(1'b0, 3'd2, 32'h200, 32'd0, 32'h12345678, 100);
        access(1'b0, 3'd1, 32'h202, 32'd0, 32'h8001ABCD, TMO - 1);

        for (int i = 0; i < 80; i++) begin
            rw  = 1'($urandom_range(0, 1));
            rf3 = 3'($urandom_range(0, 7));
            ra  = $urandom;
            if ($urandom_range(0, 3) != 0) ra[1:0] = 2'b00;
            access(rw, rf3, ra, $urandom, $urandom, $urandom_range(0, 5));
        end

        // reset mid-handshake drops the pending access
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        funct3    = 3'd2;
        addr      = 32'h40;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_busy_req", mem_req, 1);
        @(negedge clk);
        rst_n     = 1'b0;
        req_valid = 1'b0;
        @(negedge clk);
        chk("rst_busy_req_drop", mem_req, 0);
        chk("rst_busy_stall", stall, 0);
        chk("rst_busy_done", done, 0);
        chk("rst_busy_rdata", rdata, 0);
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        mem_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        mem_ready = 1'b0;
        chk("late_ready_done", done, 0);
        chk("late_ready_req", mem_req, 0);
        @(negedge clk);
        chk("late_ready_done2", done, 0);
        chk("late_ready_rdata", rdata, 0);
        exp_rdata = 32'd0;

        access(1'b0, 3'd0, 32'h7, 32'd0, 32'h7F000000, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
